arp_request_gen: RTL and testbench

//  ARP initiator; runs opposite the ARP responder. Resolves a target IPv4 address to a MAC:
//  - on request, builds a 64-byte broadcast ARP request and hands it to the MAC TX arbiter

---
 rtl/arp_request_gen_if.sv | 31 +++
 rtl/arp_request_gen.sv | 148 ++++++++++++++
 tb/tb_arp_request_gen.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arp_request_gen_if.sv
// Request, reply-report, TX-arbiter and result signals of the ARP initiator.
interface arp_request_gen_if;
    logic        req_en;
    logic [31:0] req_ip;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        rx_ack;
    logic [31:0] reply_ip;
    logic [47:0] reply_mac;
    logic        reply_en;
    logic        tx_ready;
    logic [7:0]  arp_dout;
    logic        arp_dout_en;
    logic        busy;
    logic [31:0] resolved_ip;
    logic [47:0] resolved_mac;
    logic        resolved_valid;
    logic        resolve_fail;

    modport master (
        input  req_en, req_ip, local_mac, local_ip, rx_ack, reply_ip, reply_mac, reply_en,
        output tx_ready, arp_dout, arp_dout_en, busy, resolved_ip, resolved_mac,
        output resolved_valid, resolve_fail
    );

    modport slave (
        output req_en, req_ip, local_mac, local_ip, rx_ack, reply_ip, reply_mac, reply_en,
        input  tx_ready, arp_dout, arp_dout_en, busy, resolved_ip, resolved_mac,
        input  resolved_valid, resolve_fail
    );
endinterface

// File: rtl/arp_request_gen.sv
// ARP initiator: sends a broadcast request per attempt, waits for the reply, retries, reports; frame starts the cycle after rx_ack,
// result pulses one cycle after DONE/FAIL; stalls in REQ_READY until granted. Optional single-entry cache: ARP_REQ_CACHE_EN.
module arp_request_gen #(
    parameter logic [6:0]  DATA_LEN    = 7'd64,
    parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
    parameter logic [2:0]  RETRY_MAX   = 3'd3
) (
    input  logic              clk,
    input  logic              rst_n,
    arp_request_gen_if.master bus
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REQ_READY  = 3'd1;
    localparam logic [2:0] S_REQ_SEND   = 3'd2;
    localparam logic [2:0] S_WAIT_REPLY = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;
    localparam logic [2:0] S_FAIL       = 3'd5;

    logic [2:0]   r_state;
    logic [31:0]  r_tgt_ip;
    logic [6:0]   r_send_cnt;
    logic [23:0]  r_timer;
    logic [2:0]   r_retry_cnt;
    logic [31:0]  r_res_ip;
    logic [47:0]  r_res_mac;
    logic         r_res_vld;
    logic         r_res_fail;

    logic         w_reply_hit;
    logic [335:0] w_hdr;
    logic [5:0]   w_idx;
    logic [7:0]   w_byte;

    assign w_reply_hit = bus.reply_en && (bus.reply_ip == r_tgt_ip);

`ifdef ARP_REQ_CACHE_EN
    logic [31:0] r_cache_ip;
    logic [47:0] r_cache_mac;
    logic        r_cache_vld;
    logic        w_cache_hit;

    assign w_cache_hit = r_cache_vld && (bus.req_ip == r_cache_ip);

    // Every DONE reached through a reply refreshes the entry; valid only drops on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cache_ip  <= 32'd0;
            r_cache_mac <= 48'd0;
            r_cache_vld <= 1'b0;
        end else if (r_state == S_WAIT_REPLY && w_reply_hit) begin
            r_cache_ip  <= bus.reply_ip;
            r_cache_mac <= bus.reply_mac;
            r_cache_vld <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tgt_ip    <= 32'd0;
            r_send_cnt  <= 7'd0;
            r_timer     <= 24'd0;
            r_retry_cnt <= 3'd0;
            r_res_ip    <= 32'd0;
            r_res_mac   <= 48'd0;
            r_res_vld   <= 1'b0;
            r_res_fail  <= 1'b0;
        end else begin
            r_res_vld  <= (r_state == S_DONE);
            r_res_fail <= (r_state == S_FAIL);
            case (r_state)
                S_IDLE: begin
                    if (bus.req_en) begin
                        r_tgt_ip    <= bus.req_ip;
                        r_retry_cnt <= 3'd0;
`ifdef ARP_REQ_CACHE_EN
                        if (w_cache_hit) begin
                            r_res_ip  <= bus.req_ip;
                            r_res_mac <= r_cache_mac;
                            r_state   <= S_DONE;
                        end else begin
                            r_state <= S_REQ_READY;
                        end
`else
                        r_state <= S_REQ_READY;
`endif
                    end
                end
                S_REQ_READY: begin
                    if (bus.rx_ack) begin
                        r_send_cnt <= 7'd0;
                        r_state    <= S_REQ_SEND;
                    end
                end
                S_REQ_SEND: begin
                    if (r_send_cnt == DATA_LEN - 7'd1) begin
                        r_timer <= 24'd0;
                        r_state <= S_WAIT_REPLY;
                    end else begin
                        r_send_cnt <= r_send_cnt + 7'd1;
                    end
                end
                S_WAIT_REPLY: begin
                    // A matching reply beats a timeout landing on the same cycle.
                    if (w_reply_hit) begin
                        r_res_ip  <= bus.reply_ip;
                        r_res_mac <= bus.reply_mac;
                        r_state   <= S_DONE;
                    end else if (r_timer == TIMEOUT_CYC - 24'd1) begin
                        if (r_retry_cnt < RETRY_MAX) begin
                            r_retry_cnt <= r_retry_cnt + 3'd1;
                            r_state     <= S_REQ_READY;
                        end else begin
                            r_state <= S_FAIL;
                        end
                    end else begin
                        r_timer <= r_timer + 24'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAIL:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Header bytes 0..41, byte 0 in the top bits; addresses are sampled live while sending.
    assign w_hdr = {48'hFFFF_FFFF_FFFF, bus.local_mac, 16'h0806, 16'h0001, 16'h0800,
                    16'h0604, 16'h0001, bus.local_mac, bus.local_ip, 48'h0, r_tgt_ip};
    assign w_idx = 6'(7'd41 - r_send_cnt);

    always_comb begin
        w_byte = 8'h00;
        if (r_send_cnt < 7'd42) begin
            w_byte = w_hdr[{w_idx, 3'b000} +: 8];
        end
    end

    assign bus.tx_ready       = (r_state == S_REQ_READY);
    assign bus.arp_dout_en    = (r_state == S_REQ_SEND);
    assign bus.arp_dout       = (r_state == S_REQ_SEND) ? w_byte : 8'h00;
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.resolved_ip    = r_res_ip;
    assign bus.resolved_mac   = r_res_mac;
    assign bus.resolved_valid = r_res_vld;
    assign bus.resolve_fail   = r_res_fail;
endmodule

// File: tb/tb_arp_request_gen.sv
module tb_arp_request_gen;
    localparam int TO = 128;
    localparam int RM = 2;
    localparam int DL = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    typedef struct packed {
        logic        fail;
        logic [31:0] ip;
        logic [47:0] mac;
    } res_t;

    logic [7:0] byte_q[$];
    res_t       res_q[$];

    arp_request_gen_if bus();

    arp_request_gen #(
        .DATA_LEN    (7'd64),
        .TIMEOUT_CYC (24'd128),
        .RETRY_MAX   (3'd2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    function automatic logic [7:0] model_byte(int i, logic [31:0] tip, logic [47:0] lmac, logic [31:0] lip);
        if (i < 6)               return 8'hFF;
        if (i < 12)              return 8'(lmac >> (8 * (11 - i)));
        if (i >= 22 && i < 28)   return 8'(lmac >> (8 * (27 - i)));
        if (i >= 28 && i < 32)   return 8'(lip >> (8 * (31 - i)));
        if (i >= 38 && i < 42)   return 8'(tip >> (8 * (41 - i)));
        case (i)
            12: return 8'h08;
            13: return 8'h06;
            15: return 8'h01;
            16: return 8'h08;
            18: return 8'h06;
            19: return 8'h04;
            21: return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_req(input logic [31:0] ip);
        bus.req_en = 1'b1;
        bus.req_ip = ip;
        tick;
        bus.req_en = 1'b0;
    endtask

    task automatic drive_reply(input logic [31:0] ip, input logic [47:0] mac);
        bus.reply_en  = 1'b1;
        bus.reply_ip  = ip;
        bus.reply_mac = mac;
        tick;
        bus.reply_en  = 1'b0;
    endtask

    task automatic wait_tx(input int max, output int n);
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < max) begin
            tick;
            n++;
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_tx: tx_ready=%b after %0d cycles, required 1", bus.tx_ready, n);
        end
    endtask

    task automatic wait_result(input int max, output int n);
        res_t exp;
        n = 0;
        while (bus.resolved_valid !== 1'b1 && bus.resolve_fail !== 1'b1 && n < max) begin
            tick;
            n++;
        end
        checks++;
        if (bus.resolved_valid !== 1'b1 && bus.resolve_fail !== 1'b1) begin
            errors++;
            $display("FAIL result: no resolved_valid/resolve_fail within %0d cycles", max);
            if (res_q.size() > 0) exp = res_q.pop_front();
        end else if (res_q.size() == 0) begin
            errors++;
            $display("FAIL result: unexpected pulse valid=%b fail=%b", bus.resolved_valid, bus.resolve_fail);
        end else begin
            exp = res_q.pop_front();
            if (bus.resolve_fail !== exp.fail || bus.resolved_valid !== !exp.fail ||
                (!exp.fail && (bus.resolved_ip !== exp.ip || bus.resolved_mac !== exp.mac))) begin
                errors++;
                $display("FAIL result: valid=%b fail=%b ip=%h mac=%h, required fail=%b ip=%h mac=%h",
                         bus.resolved_valid, bus.resolve_fail, bus.resolved_ip, bus.resolved_mac,
                         exp.fail, exp.ip, exp.mac);
            end
        end
    endtask

    // Grants the pending request after ack_delay cycles and checks every byte against the model.
    task automatic send_frame(input logic [31:0] tip, input int ack_delay, input int stray_at, input int rst_at);
        int         n;
        logic [7:0] exp;
        wait_tx(1000, n);
        repeat (ack_delay) begin
            tick;
            checks++;
            if (bus.tx_ready !== 1'b1 || bus.arp_dout_en !== 1'b0) begin
                errors++;
                $display("FAIL hold: tx_ready=%b en=%b, required 1/0", bus.tx_ready, bus.arp_dout_en);
            end
        end
        bus.rx_ack = 1'b1;
        for (int i = 0; i < DL; i++) byte_q.push_back(model_byte(i, tip, bus.local_mac, bus.local_ip));
        tick;
        bus.rx_ack = 1'b0;
        for (int i = 0; i < DL; i++) begin
            exp = byte_q.pop_front();
            checks++;
            if (bus.arp_dout_en !== 1'b1 || bus.arp_dout !== exp) begin
                errors++;
                $display("FAIL frame byte %0d: en=%b dout=%h, required en=1 dout=%h", i, bus.arp_dout_en, bus.arp_dout, exp);
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (bus.arp_dout_en !== 1'b0 || bus.tx_ready !== 1'b0 || bus.busy !== 1'b0 || bus.arp_dout !== 8'h00) begin
                    errors++;
                    $display("FAIL async reset: en=%b tx_ready=%b busy=%b dout=%h, required all 0",
                             bus.arp_dout_en, bus.tx_ready, bus.busy, bus.arp_dout);
                end
                byte_q.delete();
                repeat (2) tick;
                rst_n = 1'b1;
                tick;
                return;
            end
            if (i == stray_at) begin
                bus.req_en = 1'b1;
                bus.req_ip = 32'hDEAD_BEEF;
            end
            tick;
            bus.req_en = 1'b0;
        end
        checks++;
        if (bus.arp_dout_en !== 1'b0 || bus.busy !== 1'b1 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame end: en=%b busy=%b tx_ready=%b, required 0/1/0", bus.arp_dout_en, bus.busy, bus.tx_ready);
        end
    endtask

    task automatic test_reset;
        bus.req_en = 1'b0;  bus.req_ip = 32'd0;   bus.rx_ack = 1'b0;
        bus.reply_en = 1'b0; bus.reply_ip = 32'd0; bus.reply_mac = 48'd0;
        bus.local_mac = 48'h0A0B_0C0D_0E0F;
        bus.local_ip  = 32'hC0A8_0101;
        rst_n = 1'b0;
        tick;
        checks++;
        if ({bus.tx_ready, bus.arp_dout_en, bus.busy, bus.resolved_valid, bus.resolve_fail} !== 5'b0 ||
            bus.arp_dout !== 8'h00 || bus.resolved_ip !== 32'd0 || bus.resolved_mac !== 48'd0) begin
            errors++;
            $display("FAIL reset: tx=%b en=%b busy=%b vld=%b fail=%b dout=%h ip=%h mac=%h, required all 0",
                     bus.tx_ready, bus.arp_dout_en, bus.busy, bus.resolved_valid, bus.resolve_fail,
                     bus.arp_dout, bus.resolved_ip, bus.resolved_mac);
        end
        rst_n = 1'b1;
        tick;
        // A matching-looking reply while idle must not produce a result.
        drive_reply(32'hC0A8_0105, 48'h1111_1111_1111);
        repeat (2) tick;
        checks++;
        if (bus.resolved_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle reply: valid=%b busy=%b, required 0/0", bus.resolved_valid, bus.busy);
        end
    endtask

    task automatic test_basic;
        int n;
        do_req(32'hC0A8_0105);
        send_frame(32'hC0A8_0105, 3, -1, -1);
        repeat (99) tick;
        res_q.push_back('{1'b0, 32'hC0A8_0105, 48'h0011_2233_4455});
        drive_reply(32'hC0A8_0105, 48'h0011_2233_4455);
        wait_result(10, n);
        checks++;
        if (n !== 1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic latency: n=%0d busy=%b, required n=1 busy=0", n, bus.busy);
        end
        tick;
        checks++;
        if (bus.resolved_valid !== 1'b0 || bus.resolved_mac !== 48'h0011_2233_4455) begin
            errors++;
            $display("FAIL basic hold: valid=%b mac=%h, required 0 / 001122334455", bus.resolved_valid, bus.resolved_mac);
        end
    endtask

    task automatic test_cache;
        int n;
        do_req(32'hC0A8_0105);
`ifdef ARP_REQ_CACHE_EN
        res_q.push_back('{1'b0, 32'hC0A8_0105, 48'h0011_2233_4455});
        checks++;
        if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL cache hit: tx_ready=%b busy=%b, required 0/1", bus.tx_ready, bus.busy);
        end
        wait_result(10, n);
`else
        send_frame(32'hC0A8_0105, 0, -1, -1);
        repeat (10) tick;
        res_q.push_back('{1'b0, 32'hC0A8_0105, 48'h0066_7788_99AA});
        drive_reply(32'hC0A8_0105, 48'h0066_7788_99AA);
        wait_result(10, n);
`endif
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL cache latency: n=%0d, required 1", n);
        end
        tick;
    endtask

    task automatic test_timeout_retry;
        int n;
        bus.local_mac = 48'h0212_3456_789A;
        bus.local_ip  = 32'h0A00_0001;
        do_req(32'hC0A8_0107);
        send_frame(32'hC0A8_0107, 0, -1, -1);
        for (int a = 1; a <= RM; a++) begin
            wait_tx(TO + 10, n);
            checks++;
            if (n !== TO) begin
                errors++;
                $display("FAIL retry %0d gap: %0d cycles, required %0d", a, n, TO);
            end
            send_frame(32'hC0A8_0107, 0, -1, -1);
        end
        res_q.push_back('{1'b1, 32'd0, 48'd0});
        wait_result(TO + 10, n);
        checks++;
        if (n !== TO + 1 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL fail latency: n=%0d tx_ready=%b, required %0d/0", n, bus.tx_ready, TO + 1);
        end
        tick;
    endtask

    task automatic test_nonmatch_edge;
        int n;
        do_req(32'hC0A8_0105);
        send_frame(32'hC0A8_0105, 0, -1, -1);
        repeat (5) tick;
        drive_reply(32'hC0A8_0109, 48'hBAD0_BAD0_BAD0);
        checks++;
        if (bus.busy !== 1'b1 || bus.resolved_valid !== 1'b0 || bus.tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL nonmatch: busy=%b valid=%b tx=%b, required 1/0/0", bus.busy, bus.resolved_valid, bus.tx_ready);
        end
        wait_tx(TO, n);
        checks++;
        if (n !== TO - 6) begin
            errors++;
            $display("FAIL nonmatch timer: retry after %0d more cycles, required %0d", n, TO - 6);
        end
        send_frame(32'hC0A8_0105, 0, -1, -1);
        repeat (TO - 1) tick;
        res_q.push_back('{1'b0, 32'hC0A8_0105, 48'h00AA_BBCC_DDEE});
        drive_reply(32'hC0A8_0105, 48'h00AA_BBCC_DDEE);
        checks++;
        if (bus.tx_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL edge reply: tx_ready=%b busy=%b, required 0/1", bus.tx_ready, bus.busy);
        end
        wait_result(10, n);
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL edge latency: n=%0d, required 1", n);
        end
        tick;
    endtask

    task automatic test_ignore;
        int n;
        do_req(32'hC0A8_0111);
        send_frame(32'hC0A8_0111, 1, 10, -1);
        bus.rx_ack = 1'b1;
        repeat (3) begin
            tick;
            checks++;
            if (bus.arp_dout_en !== 1'b0 || bus.tx_ready !== 1'b0) begin
                errors++;
                $display("FAIL stray ack: en=%b tx_ready=%b, required 0/0", bus.arp_dout_en, bus.tx_ready);
            end
        end
        bus.rx_ack = 1'b0;
        drive_reply(32'hDEAD_BEEF, 48'hDEAD_DEAD_DEAD);
        checks++;
        if (bus.busy !== 1'b1 || bus.resolved_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray req target: busy=%b valid=%b, required 1/0", bus.busy, bus.resolved_valid);
        end
        res_q.push_back('{1'b0, 32'hC0A8_0111, 48'h0CAF_E000_0111});
        drive_reply(32'hC0A8_0111, 48'h0CAF_E000_0111);
        wait_result(10, n);
        tick;
    endtask

    task automatic test_reset_mid_frame;
        int n;
        do_req(32'hC0A8_0120);
        send_frame(32'hC0A8_0120, 0, -1, 20);
        checks++;
        if (bus.busy !== 1'b0 || bus.resolved_mac !== 48'd0) begin
            errors++;
            $display("FAIL post reset: busy=%b mac=%h, required 0/0", bus.busy, bus.resolved_mac);
        end
        bus.local_mac = 48'h0ABC_DEF0_1234;
        do_req(32'hC0A8_0105);
        send_frame(32'hC0A8_0105, 2, -1, -1);
        repeat (7) tick;
        res_q.push_back('{1'b0, 32'hC0A8_0105, 48'h0077_8899_AABB});
        drive_reply(32'hC0A8_0105, 48'h0077_8899_AABB);
        wait_result(10, n);
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_cache;
        test_timeout_retry;
        test_nonmatch_edge;
        test_ignore;
        test_reset_mid_frame;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
